// File: rtl/mux_oht.sv
// Registered one-hot multiplexer: selects one of WIDTH data inputs by a one-hot
// select and registers the selected value together with an "any select set" flag.
module mux_oht #(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 16,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] oht,
  input  DAT_T             ary [WIDTH-1:0],
  output logic             vld,
  output DAT_T             dat
);

  localparam int DW = $bits(DAT_T);

  logic          vld_d, vld_q;
  logic [DW-1:0] dat_d, dat_q;

  assign vld_d = |oht;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("mux_oht: WIDTH must be at least 1");
    end

    if (IMPLEMENTATION == 0) begin : g_and_or
      // Every entry is gated by its own select bit, so several set bits merge.
      always_comb begin
        dat_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
          dat_d = dat_d | (DW'(ary[i]) & {DW{oht[i]}});
        end
      end
    end else if (IMPLEMENTATION == 1) begin : g_priority
      // Later indices overwrite earlier ones, so the highest set bit wins.
      always_comb begin
        dat_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (oht[i]) begin
            dat_d = DW'(ary[i]);
          end
        end
      end
    end else begin : g_bad_impl
      $error("mux_oht: IMPLEMENTATION must be 0 or 1");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = DAT_T'(dat_q);

endmodule

// File: tb/tb_mux_oht.sv
// Directed bench for mux_oht: both architectures side by side, ary[i] = i,
// checked one cycle after each stimulus with immediate assertions.
module tb_mux_oht;

  logic        clk;
  logic        rst_n;
  logic [15:0] oht;
  logic [7:0]  ary [15:0];
  logic        vld0, vld1;
  logic [7:0]  dat0, dat1;

  int compared   = 0;
  int mismatched = 0;

  mux_oht #(.DAT_T(logic [7:0]), .WIDTH(16), .IMPLEMENTATION(0)) dutAndOr (
    .clk(clk), .rst_n(rst_n), .oht(oht), .ary(ary), .vld(vld0), .dat(dat0)
  );

  mux_oht #(.DAT_T(logic [7:0]), .WIDTH(16), .IMPLEMENTATION(1)) dutPrio (
    .clk(clk), .rst_n(rst_n), .oht(oht), .ary(ary), .vld(vld1), .dat(dat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) ary[i] = 8'(i);
  end

  task automatic checkOutput(input string tag, input logic expVld,
                             input logic [7:0] expDat0, input logic [7:0] expDat1);
    compared++;
    assert (vld0 === expVld) else begin
      mismatched++;
      $error("[TB] FAIL %s impl0 vld: got %b expected %b", tag, vld0, expVld);
    end
    compared++;
    assert (dat0 === expDat0) else begin
      mismatched++;
      $error("[TB] FAIL %s impl0 dat: got %h expected %h", tag, dat0, expDat0);
    end
    compared++;
    assert (vld1 === expVld) else begin
      mismatched++;
      $error("[TB] FAIL %s impl1 vld: got %b expected %b", tag, vld1, expVld);
    end
    compared++;
    assert (dat1 === expDat1) else begin
      mismatched++;
      $error("[TB] FAIL %s impl1 dat: got %h expected %h", tag, dat1, expDat1);
    end
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic applyStimulus(input logic [15:0] sel);
    @(negedge clk);
    oht = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    oht   = 16'h00FF;
    #12;
    checkOutput("reset", 1'b0, 8'h00, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h0000);
    checkOutput("idle", 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'(1) << i);
      checkOutput($sformatf("onehot%0d", i), 1'b1, 8'(i), 8'(i));
    end

    applyStimulus(16'h0000);
    checkOutput("latencyPre", 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    oht = 16'h0008;
    #1;
    checkOutput("latencyHold", 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("latencyEdge", 1'b1, 8'h03, 8'h03);

    applyStimulus(16'h8000);
    checkOutput("preReset", 1'b1, 8'h0F, 8'h0F);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset", 1'b0, 8'h00, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("resetReleased", 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("postReset", 1'b1, 8'h0F, 8'h0F);

    applyStimulus(16'h0006);
    checkOutput("nonOneHot", 1'b1, 8'h03, 8'h02);

    applyStimulus(16'h8001);
    checkOutput("nonOneHotEnds", 1'b1, 8'h0F, 8'h0F);

    applyStimulus(16'h0000);
    checkOutput("idleEnd", 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_oht.md
MUX_OHT -- requirements
Module: mux_oht

Interface
- REQ-001: Parameter DAT_T, default logic [8-1:0]; data element type of each input and of the output.
- REQ-002: Parameter WIDTH, default 16; number of data inputs and width of the one-hot select; legal range WIDTH >= 1.
- REQ-003: Parameter IMPLEMENTATION, default 0; selects the combinational architecture, 0 = AND-OR reduction, 1 = loop priority select; any other value SHALL fail elaboration.
- REQ-004: Port clk, input, 1 bit; single clock, all state updates on its rising edge.
- REQ-005: Port rst_n, input, 1 bit; reset, asynchronous and active-low.
- REQ-006: Port oht, input, [WIDTH-1:0]; one-hot select, bit i selects ary[i].
- REQ-007: Port ary, input, unpacked array DAT_T [WIDTH-1:0]; data inputs.
- REQ-008: Port vld, output, 1 bit; registered "a select bit is set" flag.
- REQ-009: Port dat, output, DAT_T; registered selected data.

Function
- REQ-010: The combinational next valid SHALL be the OR-reduction of all oht bits.
- REQ-011: With oht one-hot at bit i, the combinational next data SHALL equal ary[i] for both implementations.
- REQ-012: With oht all zero, the next data SHALL be all zeros and next valid 0, for both implementations.
- REQ-013: IMPLEMENTATION 0 SHALL compute next data as the bitwise OR over i of (ary[i] AND replicate(oht[i])); for non-one-hot oht the result is the OR of all selected entries.
- REQ-014: IMPLEMENTATION 1 SHALL compute next data by iterating i from 0 to WIDTH-1 and taking ary[i] when oht[i] is set, starting from all zeros; for non-one-hot oht the highest set index wins.
- REQ-015: vld and dat SHALL be registered with latency exactly one clk cycle: values sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- REQ-016: The output register SHALL update every cycle, with no enable and no stall.
- REQ-017: No X-propagation masking is required; X on an unselected ary entry SHALL NOT affect dat when oht is one-hot (AND-OR/selection by construction).
- REQ-018: The design SHALL be fully synthesizable, without latches or combinational loops, and contain no other state.

Reset
- REQ-019: While rst_n is 0, vld SHALL be 0 and dat SHALL be all zeros, asynchronously, independent of clk.
- REQ-020: On rst_n deassertion, the first rising clk edge with rst_n high SHALL load the registers from the current oht/ary.
- REQ-021: Assertion of rst_n mid-operation SHALL immediately clear vld and dat, with no other side effects.

Verification
- REQ-022: Bench ties ary[i] = i, WIDTH=16, DAT_T 8-bit, and instantiates both implementations side by side against one reference model (REQ-010..014 one-hot semantics), checking one cycle after each stimulus.
- REQ-023: Idle: oht = 0 -> next cycle vld = 0, dat = 8'h00 on both implementations.
- REQ-024: One-hot sweep: oht = 1<<i for i = 0..15 -> next cycle vld = 1, dat = i on both implementations.
- REQ-025: Latency: oht changes 16'h0000 -> 16'h0008 between edges -> dat stays 0 until the next rising edge, then shows 8'h03.
- REQ-026: Reset mid-operation: oht = 16'h8000 with dat = 8'h0F, then rst_n pulled low between edges -> vld = 0, dat = 0 immediately; after release and one edge, dat = 8'h0F again.
- REQ-027: Non-one-hot: oht = 16'h0006 (entries 1,2) -> IMPLEMENTATION 0 dat = 8'h03, IMPLEMENTATION 1 dat = 8'h02; vld = 1 on both.
